// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RISC-V style controller.
// Holds the FSM state encoding, the decoded opcode constants and the encodings of every
// datapath mux/ALU select the controller drives, plus the immediate-format helper.
package multicycle_controller_pkg;

  // Width of the state encoding; the top pads/truncates it onto o_state.
  localparam int STATE_ENC_W = 4;

  typedef enum logic [STATE_ENC_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BEQ       = 4'd9,
    S_JALR      = 4'd10,
    S_JAL       = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  // Major opcodes recognised by the decoder.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Memory address source.
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // Result mux.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand A.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation class.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, never on the FSM state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    logic [1:0] imm;
    imm = IMM_I;
    case (opcode)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle for the multicycle controller.
// Ports: i_opcode/i_zero/i_mem_ready flow into the controller; all o_* select,
// strobe, debug-state and trap signals flow out. slave = controller, master = datapath.
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         i_opcode;
  logic               i_zero;
  logic               i_mem_ready;
  logic               o_mem_req;
  logic               o_adr_src;
  logic               o_mem_write;
  logic               o_ir_write;
  logic               o_pc_write;
  logic               o_reg_write;
  logic [1:0]         o_result_src;
  logic [1:0]         o_alu_src_a;
  logic [1:0]         o_alu_src_b;
  logic [1:0]         o_alu_op;
  logic [1:0]         o_imm_src;
  logic [STATE_W-1:0] o_state;
  logic               o_trap;

  modport slave (
    input  i_opcode, i_zero, i_mem_ready,
    output o_mem_req, o_adr_src, o_mem_write, o_ir_write, o_pc_write, o_reg_write,
           o_result_src, o_alu_src_a, o_alu_src_b, o_alu_op, o_imm_src, o_state, o_trap
  );

  modport master (
    output i_opcode, i_zero, i_mem_ready,
    input  o_mem_req, o_adr_src, o_mem_write, o_ir_write, o_pc_write, o_reg_write,
           o_result_src, o_alu_src_a, o_alu_src_b, o_alu_op, o_imm_src, o_state, o_trap
  );
endinterface

// File: rtl/multicycle_controller_next_state.sv
// mc_next_state: combinational next-state function of the multicycle controller FSM.
// Ports: state_i (current state), opcode_i (held instruction opcode), mem_ready_i
// (memory completes this cycle) -> state_o. Reset is applied by the state register, not here.
// Optional: ILLEGAL_OP_TRAP_EN sends unknown opcodes to TRAP instead of back to FETCH.
module mc_next_state
  import multicycle_controller_pkg::*;
(
  input  state_t     state_i,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  output state_t     state_o
);

  always_comb begin
    state_o = S_FETCH;
    case (state_i)
      S_FETCH:     state_o = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_LOAD, OP_STORE: state_o = S_MEM_ADR;
          OP_RTYPE:          state_o = S_EXEC_R;
          OP_ITYPE:          state_o = S_EXEC_I;
          OP_BRANCH:         state_o = S_BEQ;
          OP_JAL:            state_o = S_JAL;
          OP_JALR:           state_o = S_JALR;
`ifdef ILLEGAL_OP_TRAP_EN
          default:           state_o = S_TRAP;
`else
          // PC was already advanced in FETCH, so an unknown opcode behaves as a NOP.
          default:           state_o = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADR:   state_o = (opcode_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_o = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_o = S_FETCH;
      S_MEM_WRITE: state_o = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    state_o = S_ALU_WB;
      S_EXEC_I:    state_o = S_ALU_WB;
      S_ALU_WB:    state_o = S_FETCH;
      S_BEQ:       state_o = S_FETCH;
      // JALR computes its target into ALUOut, then shares JAL's PC load and link write.
      S_JALR:      state_o = S_JAL;
      S_JAL:       state_o = S_ALU_WB;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:      state_o = S_TRAP;
`else
      S_TRAP:      state_o = S_FETCH;
`endif
      default:     state_o = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller top: Moore FSM sequencing fetch/decode/execute for a small RISC-V subset.
// Ports: i_clk, i_rst (synchronous, active-high), bus (slave modport: opcode/zero/mem_ready in;
// mux selects, strobes, o_state debug and o_trap out). Optional: ILLEGAL_OP_TRAP_EN enables TRAP.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  multicycle_controller_if.slave  bus
);

  state_t state_q;
  state_t state_d;

  // Raw (pre-reset-gating) control decode of the current state.
  logic       mem_req;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;

  mc_next_state u_next_state (
    .state_i     (state_q),
    .opcode_i    (bus.i_opcode),
    .mem_ready_i (bus.i_mem_ready),
    .state_o     (state_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    adr_src    = ADR_PC;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight to the PC through the ALU result path; IR and PC
        // load only in the cycle the memory actually returns the instruction.
        mem_req    = 1'b1;
        adr_src    = ADR_PC;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURESULT;
        ir_write   = bus.i_mem_ready;
        pc_write   = bus.i_mem_ready;
      end
      S_DECODE: begin
        // Speculatively form oldPC+imm so BEQ/JAL find their target in ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        mem_req    = 1'b1;
        adr_src    = ADR_ALUOUT;
        result_src = RES_ALUOUT;
      end
      S_MEM_WB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req   = 1'b1;
        adr_src   = ADR_ALUOUT;
        mem_write = bus.i_mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        // ALUOut still holds the DECODE-computed target while the ALU compares.
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = bus.i_zero;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_JAL: begin
        // PC <- ALUOut (target) while the ALU forms oldPC+4 for the link write in ALU_WB.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      default: begin
        // TRAP and unused encodings drive nothing.
      end
    endcase
  end

  // Reset overrides every strobe so an access in flight is abandoned cleanly.
  assign bus.o_mem_req    = mem_req   & ~i_rst;
  assign bus.o_mem_write  = mem_write & ~i_rst;
  assign bus.o_ir_write   = ir_write  & ~i_rst;
  assign bus.o_pc_write   = pc_write  & ~i_rst;
  assign bus.o_reg_write  = reg_write & ~i_rst;
  assign bus.o_adr_src    = adr_src;
  assign bus.o_result_src = result_src;
  assign bus.o_alu_src_a  = alu_src_a;
  assign bus.o_alu_src_b  = alu_src_b;
  assign bus.o_alu_op     = alu_op;
  assign bus.o_imm_src    = imm_src_of(bus.i_opcode);
  assign bus.o_state      = STATE_W'(state_q);

`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.o_trap = (state_q == S_TRAP) & ~i_rst;
`else
  assign bus.o_trap = 1'b0;
`endif

endmodule
